// File: rtl/neuron_writeback.sv
// rtl/neuron_writeback.sv - accumulate, rescale, saturate and queue neuron results for BRAM write-back
// Optional ReLU on the written result: define NEURON_WRITEBACK_RELU_EN.
module neuron_writeback #(
  parameter int ACC_W      = 32,
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_load,
  input  logic [15:0]             cfg_total,
  input  logic                    add_done,
  input  logic signed [ACC_W-1:0] partial_sum,
  input  logic                    neuron_done,
  input  logic [15:0]             out_addr,
  output logic                    wr_en,
  output logic [15:0]             wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_ready,
  output logic                    fifo_full,
  output logic                    overflow,
  output logic                    busy,
  output logic                    layer_done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]               pushed_q, pushed_d;
  logic [15:0]               total_q, total_d;
  logic                      overflow_q, overflow_d;
  logic [PW:0]               wptr_q, wptr_d, rptr_q, rptr_d;

  logic [15:0]               mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]         mem_data [FIFO_DEPTH];

  logic                      fifo_empty, pop, push_req, push_ok;
  logic signed [ACC_W-1:0]   sum, shifted;
  logic [ACC_W-DATA_W:0]     top_bits;
  logic [DATA_W-1:0]         result;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign wr_en      = !fifo_empty;
  assign wr_addr    = fifo_empty ? 16'd0 : mem_addr[rptr_q[PW-1:0]];
  assign wr_data    = fifo_empty ? '0 : mem_data[rptr_q[PW-1:0]];
  assign pop        = wr_en && wr_ready;
  assign push_req   = (state_q == ACCUM) && neuron_done;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);
  assign layer_done = (state_q == DONE);

  // Saturate when the bits above the result's sign bit disagree with it.
  always_comb begin
    sum      = acc_q + (add_done ? partial_sum : '0);
    shifted  = sum >>> FRAC_BITS;
    top_bits = shifted[ACC_W-1:DATA_W-1];
    if (!(&top_bits) && (|top_bits))
      result = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      result = shifted[DATA_W-1:0];
`ifdef NEURON_WRITEBACK_RELU_EN
    if (result[DATA_W-1])
      result = '0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pushed_d   = pushed_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    wptr_d     = wptr_q + {{PW{1'b0}}, push_ok};
    rptr_d     = rptr_q + {{PW{1'b0}}, pop};
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          acc_d      = '0;
          pushed_d   = 16'd0;
          overflow_d = 1'b0;
          total_d    = cfg_total;
          state_d    = (cfg_total == 16'd0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (neuron_done) begin
          acc_d    = '0;
          pushed_d = pushed_q + 16'd1;
          if (!push_ok)
            overflow_d = 1'b1;
          if (pushed_q + 16'd1 == total_q)
            state_d = DRAIN;
        end else if (add_done) begin
          acc_d = acc_q + partial_sum;
        end
      end
      DRAIN: begin
        if (wptr_d == rptr_d)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pushed_q   <= 16'd0;
      total_q    <= 16'd0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pushed_q   <= pushed_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wptr_q[PW-1:0]] <= out_addr;
      mem_data[wptr_q[PW-1:0]] <= result;
    end
  end

endmodule

// File: tb/tb_neuron_writeback.sv
// tb/tb_neuron_writeback.sv - scoreboard bench for neuron_writeback (honours NEURON_WRITEBACK_RELU_EN)
module tb_neuron_writeback;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_load = 1'b0;
  logic [15:0]        cfg_total = 16'd0;
  logic               add_done = 1'b0;
  logic signed [31:0] partial_sum = 32'sd0;
  logic               neuron_done = 1'b0;
  logic [15:0]        out_addr = 16'd0;
  logic               wr_en;
  logic [15:0]        wr_addr;
  logic [15:0]        wr_data;
  logic               wr_ready = 1'b0;
  logic               fifo_full, overflow, busy, layer_done;

  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 cyc = 0;
  int                 last_pop_cyc = 0;
  int                 wr_count = 0;
  bit                 saw_pop = 1'b0;
  logic [31:0]        sb [$];
  logic signed [31:0] tb_acc = 32'sd0;

  neuron_writeback dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_total(cfg_total),
    .add_done(add_done), .partial_sum(partial_sum), .neuron_done(neuron_done),
    .out_addr(out_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_full(fifo_full), .overflow(overflow),
    .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic signed [31:0] s32);
    longint s;
    logic [15:0] r;
    s = longint'(s32);
    s = s / 256 - ((s % 256 != 0 && s < 0) ? 1 : 0);
    if (s > 32767) r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else r = 16'(s);
`ifdef NEURON_WRITEBACK_RELU_EN
    if (s < 0) r = 16'h0000;
`endif
    return r;
  endfunction

  // Write-port monitor: every accepted write must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && wr_en && wr_ready) begin
      wr_count++;
      if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("wr_addr", {16'd0, wr_addr}, {16'd0, e[31:16]});
        chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
      end
      saw_pop = 1'b1;
      last_pop_cyc = cyc;
    end
    if (rst && layer_done && saw_pop) begin
      chk("layer_done_latency", 32'(cyc - last_pop_cyc), 32'd1);
      saw_pop = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] total);
    saw_pop = 1'b0;
    tb_acc = 32'sd0;
    cfg_load = 1'b1;
    cfg_total = total;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic add(input logic signed [31:0] ps);
    add_done = 1'b1;
    partial_sum = ps;
    tb_acc = tb_acc + ps;
    tick();
    add_done = 1'b0;
  endtask

  task automatic fin(input logic [15:0] addr, input bit same, input logic signed [31:0] ps, input bit expect_kept);
    neuron_done = 1'b1;
    out_addr = addr;
    add_done = same;
    partial_sum = ps;
    if (same) tb_acc = tb_acc + ps;
    if (expect_kept) sb.push_back({addr, model(tb_acc)});
    tb_acc = 32'sd0;
    tick();
    neuron_done = 1'b0;
    add_done = 1'b0;
  endtask

  task automatic wait_layer_done();
    int k;
    for (k = 0; k < 50; k++) begin
      if (layer_done) break;
      tick();
    end
    chk("layer_done_seen", {31'd0, layer_done}, 32'd1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_outputs", {26'd0, wr_en, wr_addr != 16'd0, fifo_full, overflow, busy, layer_done}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic layer
    wr_ready = 1'b1;
    do_load(16'd1);
    chk("busy_after_load", {31'd0, busy}, 32'd1);
    add(32'sh0000_0300);
    add(32'sh0000_0100);
    fin(16'h0040, 1'b0, 32'sd0, 1'b1);
    chk("finalize_latency", {31'd0, wr_en}, 32'd1);
    wait_layer_done();
    tick();
    chk("idle_after_layer", {31'd0, busy}, 32'd0);

    // Saturation with same-cycle finalize, then ReLU case
    do_load(16'd3);
    fin(16'h0010, 1'b1, 32'sh0100_0000, 1'b1);
    fin(16'h0011, 1'b1, 32'shFF00_0000, 1'b1);
    add(32'shFFFF_FE00);
    fin(16'h0012, 1'b0, 32'sd0, 1'b1);
    wait_layer_done();
    tick();

    // Backpressure: fifth result is dropped
    wr_ready = 1'b0;
    do_load(16'd5);
    for (int i = 0; i < 5; i++) begin
      add(32'(i * 256 + 512));
      fin(16'h0100 + 16'(i), 1'b0, 32'sd0, i < 4);
      if (i == 3) chk("fifo_full_after_4", {31'd0, fifo_full}, 32'd1);
    end
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    chk("busy_in_drain", {31'd0, busy}, 32'd1);
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_consecutive_wr", {31'd0, wr_en}, 32'd1);
      tick();
    end
    wait_layer_done();
    tick();

    // Zero-size layer
    begin
      int wc;
      wc = wr_count;
      do_load(16'd0);
      chk("zero_layer_done", {31'd0, layer_done}, 32'd1);
      chk("overflow_cleared", {31'd0, overflow}, 32'd0);
      chk("zero_no_wr_en", {31'd0, wr_en}, 32'd0);
      tick();
      chk("zero_pulse_one_cycle", {31'd0, layer_done}, 32'd0);
      chk("zero_no_writes", 32'(wr_count - wc), 32'd0);
    end

    // Asynchronous reset mid-layer
    wr_ready = 1'b0;
    do_load(16'd5);
    for (int i = 0; i < 4; i++)
      fin(16'h0200 + 16'(i), 1'b1, 32'sh0000_1000, 1'b1);
    chk("fifo_full_pre_reset", {31'd0, fifo_full}, 32'd1);
    add_done = 1'b1;
    partial_sum = 32'sh0000_7000;
    tick();
    add_done = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_async", {29'd0, wr_en, busy, fifo_full}, 32'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    wr_ready = 1'b1;
    tick();
    chk("empty_after_reset", {31'd0, wr_en}, 32'd0);
    do_load(16'd1);
    fin(16'h0300, 1'b1, 32'sh0000_0200, 1'b1);
    wait_layer_done();
    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
